cam: RTL and testbench
======================

# cam

Content-addressable memory of 2^CAM_AW entries × CAM_DW bits, with a per-entry valid bit. Entries are written by address. A masked search key is matched in parallel against the low CAM_MW bits of every valid entry. The lowest matching address and its full data word are returned through a hold-until-acknowledged result interface. The block serves as a lookup table beside a datapath controller, which writes entries and issues searches.

## Interface
- CAM_DW, 32: entry data width.
- CAM_MW, 3: search key / strobe width; compared against entry bits [CAM_MW-1:0]; must satisfy 1 ≤ CAM_MW ≤ CAM_DW.
- CAM_AW, 8: address width; depth = 2^CAM_AW.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  CAM_DW  write data.
- addr_in  in  CAM_AW  write address.
- input_valid  in  1  write strobe; one entry is written per sampled-high cycle.
- mask_in  in  CAM_MW  search key.
- mask_strb  in  CAM_MW  compare enable per key bit (1 = compare, 0 = don't care).
- mask_en  in  1  search request; a search is issued every cycle it is sampled high while data_ready=1.
- data_valid  in  1  consumer acknowledge of a pending hit.
- hit  out  1  a pending search result matched.
- addr_out  out  CAM_AW  matching address.
- data_out  out  CAM_DW  full stored word at addr_out.
- data_ready  out  1  high when no result is pending, so searches are accepted.

## Operation
- Storage: entry[i] is CAM_DW data bits plus valid[i].
- Write: when input_valid=1 at a rising edge, entry[addr_in] <= data_in and valid[addr_in] <= 1. Writes are always accepted, including while a result is pending. Rewriting an address overwrites it.
- Match rule: entry i matches when valid[i]=1 and ((entry[i][CAM_MW-1:0] ^ mask_in) & mask_strb) == 0.
  - mask_strb=0 matches any valid entry.
  - Invalid entries never match.
- Priority: with multiple matches, the lowest address wins.
- Search, when mask_en=1 and data_ready=1 at an edge:
  - Any match: hit <= 1, addr_out <= winning address, data_out <= its word (full CAM_DW bits), data_ready <= 0.
  - No match: hit stays 0, addr_out/data_out <= 0, data_ready stays 1.
- Pending result: hit, addr_out and data_out are frozen while data_ready=0. Later writes, including to addr_out, do not alter the held data_out. mask_en is ignored.
- Acknowledge: data_valid=1 at an edge while hit=1 clears hit, addr_out and data_out to 0 and sets data_ready=1. data_valid while hit=0 is ignored.
- States:
  - IDLE (data_ready=1) -> HOLD on a search hit.
  - HOLD (hit=1) -> IDLE on data_valid.
- Reset (asserted any time, including mid-HOLD): all valid bits cleared, entry data cleared. Outputs: hit=0, addr_out=0, data_out=0, data_ready=1.

## Timing
- Write latency: a write at edge N is visible to a search sampled at edge N+1 or later. A same-edge write and search use the pre-write contents.
- Search latency: 1 cycle; key sampled at edge N, hit/addr_out/data_out valid after edge N.
- Acknowledge latency: data_valid sampled at edge N -> hit=0 and data_ready=1 after edge N. A search may be issued at edge N+1.
- Back-to-back searches with held mask_en re-search every cycle while in IDLE.
- Match logic is fully parallel combinational over all entries into a priority encoder. Outputs are registered.

## Test plan
- Reset -> hit=0, data_ready=1, addr_out=0, data_out=0. A search with mask_strb=000 then misses because the table is empty.
- Write 0xFFFF_FFFF to addr 1, then search key=3'b110, strb=3'b111 -> no hit. Then search key=3'b110, strb=3'b110 -> hit=1, addr_out=1, data_out=0xFFFF_FFFF one cycle after sampling.
- Write 0x0000_0005 to addr 7 and 0x1234_5675 to addr 3, then search key=3'b101, strb=3'b111 -> addr_out=3 (priority). After data_valid, hit=0 and data_ready=1.
- Hold: while hit pending, write 0xDEAD_BEEF to addr_out and change mask_in -> hit/addr_out/data_out unchanged until data_valid.
- Same-edge write of addr 9 and a search matching only that entry -> miss. The next-cycle search hits addr 9.
- Assert rst_n low while hit=1 -> outputs return to reset values immediately. A repeat search misses because the entries were invalidated.

Source files
------------

// File: rtl/cam.sv
// rtl/cam.sv - masked-key content-addressable memory with lowest-address priority and held result
module cam #(
  parameter int CAM_DW = 32,
  parameter int CAM_MW = 3,
  parameter int CAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CAM_DW-1:0] data_in,
  input  logic [CAM_AW-1:0] addr_in,
  input  logic              input_valid,
  input  logic [CAM_MW-1:0] mask_in,
  input  logic [CAM_MW-1:0] mask_strb,
  input  logic              mask_en,
  input  logic              data_valid,
  output logic              hit,
  output logic [CAM_AW-1:0] addr_out,
  output logic [CAM_DW-1:0] data_out,
  output logic              data_ready
);

  localparam int DEPTH = 1 << CAM_AW;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [CAM_DW-1:0] mem   [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic              match_found;
  logic [CAM_AW-1:0] match_addr;
  logic [CAM_DW-1:0] match_data;

  // Storage: writes land regardless of search state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (input_valid) begin
      mem[addr_in]   <= data_in;
      valid[addr_in] <= 1'b1;
    end
  end

  // Scanning high-to-low lets the lowest matching address win.
  always_comb begin
    match_found = 1'b0;
    match_addr  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (((mem[i][CAM_MW-1:0] ^ mask_in) & mask_strb) == '0)) begin
        match_found = 1'b1;
        match_addr  = CAM_AW'(i);
      end
    end
  end

  assign match_data = mem[match_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mask_en && match_found) state_next = HOLD;
      HOLD: if (data_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result registers are frozen in HOLD so later writes cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_out <= '0;
      data_out <= '0;
    end else if (state == IDLE) begin
      if (mask_en) begin
        addr_out <= match_found ? match_addr : '0;
        data_out <= match_found ? match_data : '0;
      end
    end else if (data_valid) begin
      addr_out <= '0;
      data_out <= '0;
    end
  end

  assign hit        = (state == HOLD);
  assign data_ready = (state == IDLE);

endmodule

// File: tb/tb_cam.sv
// tb/tb_cam.sv - scoreboard bench for cam: directed writes, searches, holds and resets
module tb_cam;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  addr_in;
  logic        input_valid;
  logic [2:0]  mask_in;
  logic [2:0]  mask_strb;
  logic        mask_en;
  logic        data_valid;
  logic        hit;
  logic [7:0]  addr_out;
  logic [31:0] data_out;
  logic        data_ready;

  cam #(.CAM_DW(32), .CAM_MW(3), .CAM_AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .addr_in     (addr_in),
    .input_valid (input_valid),
    .mask_in     (mask_in),
    .mask_strb   (mask_strb),
    .mask_en     (mask_en),
    .data_valid  (data_valid),
    .hit         (hit),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .data_ready  (data_ready)
  );

  typedef struct {
    logic        e_hit;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cycle  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle = cycle + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (act !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_item(input exp_t e);
    cmp({e.name, ".hit"},        32'(hit),        32'(e.e_hit));
    cmp({e.name, ".addr_out"},   32'(addr_out),   32'(e.e_addr));
    cmp({e.name, ".data_out"},   data_out,        e.e_data);
    cmp({e.name, ".data_ready"}, 32'(data_ready), 32'(!e.e_hit));
  endtask

  // Monitor: compares every expectation that falls due on this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
        e = exp_q.pop_front();
        check_item(e);
      end
    end
  end

  task automatic clear_inputs();
    input_valid = 1'b0;
    addr_in     = '0;
    data_in     = '0;
    mask_en     = 1'b0;
    mask_in     = '0;
    mask_strb   = '0;
    data_valid  = 1'b0;
  endtask

  task automatic expect_next(input string name, input logic h, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.e_hit  = h;
    e.e_addr = a;
    e.e_data = d;
    e.due    = cycle + 1;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    clear_inputs();
    input_valid = 1'b1;
    addr_in     = a;
    data_in     = d;
  endtask

  task automatic do_search(input string name, input logic [2:0] key, input logic [2:0] strb,
                           input logic h, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    clear_inputs();
    mask_en   = 1'b1;
    mask_in   = key;
    mask_strb = strb;
    expect_next(name, h, a, d);
  endtask

  task automatic do_write_search(input string name, input logic [7:0] wa, input logic [31:0] wd,
                                 input logic [2:0] key, input logic [2:0] strb,
                                 input logic h, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    clear_inputs();
    input_valid = 1'b1;
    addr_in     = wa;
    data_in     = wd;
    mask_en     = 1'b1;
    mask_in     = key;
    mask_strb   = strb;
    expect_next(name, h, a, d);
  endtask

  task automatic do_ack(input string name);
    @(negedge clk);
    clear_inputs();
    data_valid = 1'b1;
    expect_next(name, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic do_nop(input string name, input logic h, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    clear_inputs();
    expect_next(name, h, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_rst;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_nop("reset", 1'b0, 8'h00, 32'h0);
    do_search("empty_strb0", 3'b000, 3'b000, 1'b0, 8'h00, 32'h0);

    do_write(8'd1, 32'hFFFF_FFFF);
    do_search("key110_strb111_miss", 3'b110, 3'b111, 1'b0, 8'h00, 32'h0);
    do_search("key110_strb110_hit", 3'b110, 3'b110, 1'b1, 8'd1, 32'hFFFF_FFFF);
    do_ack("ack1");

    do_write(8'd7, 32'h0000_0005);
    do_write(8'd3, 32'h1234_5675);
    do_search("priority_addr3", 3'b101, 3'b111, 1'b1, 8'd3, 32'h1234_5675);
    do_ack("ack2");
    do_search("strb0_lowest", 3'b010, 3'b000, 1'b1, 8'd1, 32'hFFFF_FFFF);
    do_ack("ack3");

    do_search("hold_start", 3'b101, 3'b111, 1'b1, 8'd3, 32'h1234_5675);
    do_write_search("hold_write_ignored", 8'd3, 32'hDEAD_BEEF, 3'b111, 3'b000,
                    1'b1, 8'd3, 32'h1234_5675);
    do_nop("hold_still", 1'b1, 8'd3, 32'h1234_5675);
    do_ack("ack4");
    do_ack("ack_idle_ignored");
    do_search("overwrite_seen_addr7", 3'b101, 3'b111, 1'b1, 8'd7, 32'h0000_0005);
    do_ack("ack5");

    do_write_search("same_edge_miss", 8'd9, 32'h0000_0002, 3'b010, 3'b111,
                    1'b0, 8'h00, 32'h0);
    do_search("next_edge_hit9", 3'b010, 3'b111, 1'b1, 8'd9, 32'h0000_0002);
    do_nop("hit9_held", 1'b1, 8'd9, 32'h0000_0002);

    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    e_rst.e_hit  = 1'b0;
    e_rst.e_addr = 8'h00;
    e_rst.e_data = 32'h0;
    e_rst.due    = cycle;
    e_rst.name   = "async_reset";
    check_item(e_rst);
    @(negedge clk);
    rst_n = 1'b1;
    do_search("after_reset_key010", 3'b010, 3'b111, 1'b0, 8'h00, 32'h0);
    do_search("after_reset_strb0", 3'b000, 3'b000, 1'b0, 8'h00, 32'h0);
    do_nop("final_idle", 1'b0, 8'h00, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
